// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, jump flush, data-memory
// wait with timeout abort, and a drain-then-halt sequence. All outputs are combinational.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int DRAIN_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic        ex_is_load_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_reg_wen_i,
  input  logic        ex_jump_en_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  input  logic        halt_req_i,
  output logic        halt_ack_o,
  output logic        pc_hold_o,
  output logic        if_id_hold_o,
  output logic        id_ex_hold_o,
  output logic        ex_mem_hold_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        mem_wb_bubble_o,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        mem_timeout_o
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
  localparam logic [1:0] DD  = 2'(DRAIN_DEPTH);

  state_t     state, state_nxt, ret_state, ret_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic [1:0] drain_cnt, drain_nxt;

  logic memwait, loaduse, rs1_hit, rs2_hit, drain_act;
  logic pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic if_id_flush, id_ex_flush, bubble, jump_en, timeout, ack;

  assign memwait = dmem_req_i & ~dmem_ready_i;
  assign rs1_hit = id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit = id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i);
  assign loaduse = ex_is_load_i & ex_reg_wen_i & (ex_rd_addr_i != 5'd0) & (rs1_hit | rs2_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ret_state <= RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      wait_cnt  <= wait_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ret_nxt     = ret_state;
    wait_nxt    = wait_cnt;
    drain_nxt   = drain_cnt;
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    id_ex_hold  = 1'b0;
    ex_mem_hold = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    bubble      = 1'b0;
    jump_en     = 1'b0;
    timeout     = 1'b0;
    ack         = 1'b0;
    // a halt request in RUN already stops fetch on the cycle it is seen
    drain_act   = (state == DRAIN) | halt_req_i;
    case (state)
      RUN, DRAIN: begin
        if (memwait) begin
          {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, bubble} = '1;
          state_nxt = MEM_WAIT;
          ret_nxt   = state;
          wait_nxt  = 8'd1;
        end else begin
          if (ex_jump_en_i) begin
            {jump_en, if_id_flush, id_ex_flush} = '1;
          end else if (loaduse) begin
            {pc_hold, if_id_hold, id_ex_flush} = '1;
          end else if (drain_act) begin
            {pc_hold, if_id_flush} = '1;
          end
          if (state == RUN) begin
            if (halt_req_i) begin
              state_nxt = DRAIN;
              drain_nxt = DD;
            end
          end else if (!halt_req_i) begin
            state_nxt = RUN;
          end else if (ex_jump_en_i) begin
            drain_nxt = DD;
          end else if (!loaduse) begin
            if (drain_cnt <= 2'd1) state_nxt = HALTED;
            else                   drain_nxt = drain_cnt - 2'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (memwait && wait_cnt >= TMO) begin
          // give up on the access: release the pipe and discard the MEM result
          {timeout, bubble} = '1;
          state_nxt = ret_state;
          wait_nxt  = '0;
        end else if (memwait) begin
          {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, bubble} = '1;
          wait_nxt = wait_cnt + 8'd1;
        end else begin
          state_nxt = ret_state;
          wait_nxt  = '0;
          if (ex_jump_en_i) begin
            {jump_en, if_id_flush, id_ex_flush} = '1;
            if (ret_state == DRAIN) drain_nxt = DD;
          end else if (loaduse) begin
            {pc_hold, if_id_hold, id_ex_flush} = '1;
          end
        end
      end
      HALTED: begin
        {ack, pc_hold, if_id_flush} = '1;
        if (!halt_req_i) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // hold wins over flush on the same register; everything is quiet in reset
  assign pc_hold_o       = rst_n & pc_hold;
  assign if_id_hold_o    = rst_n & if_id_hold;
  assign id_ex_hold_o    = rst_n & id_ex_hold;
  assign ex_mem_hold_o   = rst_n & ex_mem_hold;
  assign if_id_flush_o   = rst_n & if_id_flush & ~if_id_hold;
  assign id_ex_flush_o   = rst_n & id_ex_flush & ~id_ex_hold;
  assign mem_wb_bubble_o = rst_n & bubble;
  assign jump_en_o       = rst_n & jump_en;
  assign jump_addr_o     = ex_jump_addr_i;
  assign mem_timeout_o   = rst_n & timeout;
  assign halt_ack_o      = rst_n & ack;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: single-cycle vector table in RUN plus
// multi-cycle sequences for memory wait, timeout, drain/halt and reset.
module tb_pipe_ctrl;

  logic        clk, rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        u1, u2, ld, wen, jmp, req, rdy, halt;
  logic [31:0] ja;
  logic        halt_ack, pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic        if_id_flush, id_ex_flush, bubble, jump_en, tmo;
  logic [31:0] jump_addr;
  logic [9:0]  outs;

  int n_vec = 0;
  int n_bad = 0;

  pipe_ctrl #(.MEM_TIMEOUT(8), .DRAIN_DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .ex_is_load_i(ld), .ex_rd_addr_i(rd), .ex_reg_wen_i(wen),
    .ex_jump_en_i(jmp), .ex_jump_addr_i(ja),
    .dmem_req_i(req), .dmem_ready_i(rdy), .halt_req_i(halt),
    .halt_ack_o(halt_ack), .pc_hold_o(pc_hold), .if_id_hold_o(if_id_hold),
    .id_ex_hold_o(id_ex_hold), .ex_mem_hold_o(ex_mem_hold),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
    .mem_wb_bubble_o(bubble), .jump_en_o(jump_en), .jump_addr_o(jump_addr),
    .mem_timeout_o(tmo)
  );

  // {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush, bubble, jump_en, timeout, ack}
  assign outs = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush,
                 id_ex_flush, bubble, jump_en, tmo, halt_ack};

  localparam logic [9:0] O_NONE  = 10'b0000000000;
  localparam logic [9:0] O_STALL = 10'b1100010000;
  localparam logic [9:0] O_JUMP  = 10'b0000110100;
  localparam logic [9:0] O_MWAIT = 10'b1111001000;
  localparam logic [9:0] O_DRAIN = 10'b1000100000;
  localparam logic [9:0] O_HALT  = 10'b1000100001;
  localparam logic [9:0] O_TMO   = 10'b0000001010;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, ld, wen, jmp, req, rdy, halt;
    logic [31:0] ja;
    logic [9:0]  exp;
  } vec_t;

  vec_t tbl [13];
  vec_t v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [4:0] a1, input logic b1, input logic [4:0] a2,
                              input logic b2, input logic l, input logic [4:0] d,
                              input logic w, input logic j, input logic [31:0] addr,
                              input logic rq, input logic ry, input logic [9:0] e);
    vec_t r;
    r.rs1 = a1; r.u1 = b1; r.rs2 = a2; r.u2 = b2; r.ld = l; r.rd = d; r.wen = w;
    r.jmp = j; r.ja = addr; r.req = rq; r.rdy = ry; r.halt = 1'b0; r.exp = e;
    return r;
  endfunction

  function automatic vec_t idle_v();
    return mk(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, O_NONE);
  endfunction

  task automatic drv(input vec_t x);
    rs1 = x.rs1; rs2 = x.rs2; u1 = x.u1; u2 = x.u2; ld = x.ld; rd = x.rd;
    wen = x.wen; jmp = x.jmp; ja = x.ja; req = x.req; rdy = x.rdy; halt = x.halt;
  endtask

  task automatic chk(input string nm, input logic [9:0] exp);
    n_vec++;
    if (outs !== exp) begin
      n_bad++;
      $display("FAIL %s: outputs %b, required %b", nm, outs, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] exp);
    n_vec++;
    if (jump_addr !== exp) begin
      n_bad++;
      $display("FAIL %s: jump_addr %h, required %h", nm, jump_addr, exp);
    end
  endtask

  // check at the falling edge, then advance past the next rising edge
  task automatic cyc(input string nm, input logic [9:0] exp);
    @(negedge clk);
    chk(nm, exp);
    @(posedge clk);
    #1;
  endtask

  // RUN is the only state where a halt request yields drain outputs immediately
  task automatic prove_run(input string nm);
    vec_t x;
    x = idle_v(); x.halt = 1'b1; drv(x);
    cyc({nm, "_run"}, O_DRAIN);
    x.halt = 1'b0; drv(x);
    cyc({nm, "_drn"}, O_DRAIN);
    cyc({nm, "_back"}, O_NONE);
  endtask

  initial begin
    tbl[0]  = mk(5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, O_NONE);
    tbl[1]  = mk(5'd5,  1'b1, 5'd0,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, O_STALL);
    tbl[2]  = mk(5'd0,  1'b1, 5'd0,  1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, O_NONE);
    tbl[3]  = mk(5'd3,  1'b1, 5'd7,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, O_STALL);
    tbl[4]  = mk(5'd5,  1'b0, 5'd0,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, O_NONE);
    tbl[5]  = mk(5'd5,  1'b1, 5'd0,  1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 32'h0,        1'b0, 1'b0, O_NONE);
    tbl[6]  = mk(5'd5,  1'b1, 5'd0,  1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, O_NONE);
    tbl[7]  = mk(5'd5,  1'b1, 5'd0,  1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 32'h80,       1'b0, 1'b0, O_JUMP);
    tbl[8]  = mk(5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, O_JUMP);
    tbl[9]  = mk(5'd5,  1'b1, 5'd0,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 32'h0,        1'b1, 1'b1, O_STALL);
    tbl[10] = mk(5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'h1234,     1'b0, 1'b0, O_NONE);
    tbl[11] = mk(5'd9,  1'b0, 5'd9,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 32'h0,        1'b0, 1'b0, O_STALL);
    tbl[12] = mk(5'd31, 1'b1, 5'd31, 1'b1, 1'b1, 5'd30, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, O_NONE);

    // reset: hazards on every input, outputs must stay quiet except jump_addr
    rst_n = 1'b0;
    v = tbl[7]; v.req = 1'b1; v.halt = 1'b1; v.ja = 32'hCAFE0000; drv(v);
    #3;
    chk("reset_outs", O_NONE);
    chk32("reset_addr", 32'hCAFE0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drv(idle_v());

    for (int i = 0; i < 13; i++) begin
      drv(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), tbl[i].exp);
      chk32($sformatf("vec%0d_addr", i), tbl[i].ja);
      @(posedge clk); #1;
    end

    // memory wait: ready low for four cycles, then high
    v = idle_v(); v.req = 1'b1; drv(v);
    for (int i = 0; i < 4; i++) cyc($sformatf("mwait%0d", i), O_MWAIT);
    v.rdy = 1'b1; drv(v);
    cyc("mwait_release", O_NONE);
    prove_run("mwait");

    // timeout at 8 wait cycles
    v = idle_v(); v.req = 1'b1; drv(v);
    for (int i = 0; i < 8; i++) cyc($sformatf("tmo_wait%0d", i), O_MWAIT);
    cyc("tmo_pulse", O_TMO);
    drv(idle_v());
    cyc("tmo_after", O_NONE);
    prove_run("tmo");

    // halt from RUN: ack after DRAIN_DEPTH+1 cycles; HALTED ignores memwait
    v = idle_v(); v.halt = 1'b1; drv(v);
    for (int i = 0; i < 4; i++) cyc($sformatf("halt_drain%0d", i), O_DRAIN);
    cyc("halt_ack", O_HALT);
    v.req = 1'b1; drv(v);
    cyc("halt_ign_mem", O_HALT);
    v = idle_v(); drv(v);
    cyc("halt_release", O_HALT);
    cyc("halt_resume", O_NONE);

    // jump during drain reloads the count; load-use does not decrement
    v = idle_v(); v.halt = 1'b1; drv(v);
    for (int i = 0; i < 3; i++) cyc($sformatf("dj_pre%0d", i), O_DRAIN);
    v.jmp = 1'b1; v.ja = 32'h100; drv(v);
    @(negedge clk);
    chk("dj_jump", O_JUMP);
    chk32("dj_jump_addr", 32'h100);
    @(posedge clk); #1;
    v = tbl[1]; v.halt = 1'b1; drv(v);
    cyc("dj_loaduse", O_STALL);
    v = idle_v(); v.halt = 1'b1; drv(v);
    for (int i = 0; i < 3; i++) cyc($sformatf("dj_post%0d", i), O_DRAIN);
    cyc("dj_ack", O_HALT);
    v.halt = 1'b0; drv(v);
    cyc("dj_release", O_HALT);
    cyc("dj_resume", O_NONE);

    // memory wait inside drain returns to drain with count intact
    v = idle_v(); v.halt = 1'b1; drv(v);
    cyc("dm_enter", O_DRAIN);
    v.req = 1'b1; drv(v);
    cyc("dm_wait", O_MWAIT);
    v.rdy = 1'b1; drv(v);
    cyc("dm_ready", O_NONE);
    v = idle_v(); v.halt = 1'b1; drv(v);
    for (int i = 0; i < 3; i++) cyc($sformatf("dm_drain%0d", i), O_DRAIN);
    cyc("dm_ack", O_HALT);
    v.halt = 1'b0; drv(v);
    cyc("dm_release", O_HALT);
    cyc("dm_resume", O_NONE);

    // reset in the middle of a memory wait
    v = idle_v(); v.req = 1'b1; v.ja = 32'h55AA; drv(v);
    cyc("rmw_wait0", O_MWAIT);
    cyc("rmw_wait1", O_MWAIT);
    #2 rst_n = 1'b0;
    #1;
    chk("rmw_reset_outs", O_NONE);
    chk32("rmw_reset_addr", 32'h55AA);
    @(posedge clk); #1;
    drv(idle_v());
    rst_n = 1'b1;
    cyc("rmw_post", O_NONE);
    prove_run("rmw");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
